// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and stream framing constants.
package boot_pkg;

   // Loader FSM states; StHdr0 is the reset state.
   typedef enum logic [2:0] {
      StHdr0,
      StHdr1,
      StData,
      StFin,
      StRun,
      StError
   } boot_state_e;

   // Header is a 16-bit little-endian word count, one byte per header state.
   localparam int unsigned HdrBytes     = 2;
   localparam int unsigned BytesPerWord = 4;

   // States in which the loader is consuming the stream.
   function automatic logic takes_bytes(boot_state_e s);
      return (s == StHdr0) || (s == StHdr1) || (s == StData);
   endfunction

   // States in which a load is in progress (includes the final write cycle).
   function automatic logic is_busy(boot_state_e s);
      return takes_bytes(s) || (s == StFin);
   endfunction

endpackage

// File: rtl/boot_ctrl_if.sv
// Bundle of the loader byte stream, reload request and instruction-memory write port.
//   master : stream/host side (drives rx_valid, rx_data, boot_req)
//   slave  : boot_ctrl side (drives rx_ready, imem_*, core_reset, busy, error, words_loaded)
interface boot_ctrl_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        boot_req;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        busy;
   logic        error;
   logic [15:0] words_loaded;

   modport master (
      output rx_valid, rx_data, boot_req,
      input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, error, words_loaded
   );

   modport slave (
      input  rx_valid, rx_data, boot_req,
      output rx_ready, imem_we, imem_addr, imem_wdata, core_reset, busy, error, words_loaded
   );
endinterface

// File: rtl/byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
//   clk, reset : clock and async active-low reset
//   clear_i    : synchronous clear of byte index and shift register
//   valid_i    : a byte is accepted this cycle
//   byte_i     : accepted byte
//   word_o     : assembled word, valid together with done_o
//   done_o     : combinational pulse when the 4th byte of a word is accepted
module byte_packer
   import boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        done_o
);

   localparam logic [1:0] LastIdx = 2'(BytesPerWord - 1);

   logic [1:0]  idx_q;
   logic [31:0] shift_q;

   // Bytes enter at the top and shift down, so the first byte ends up in bits 7:0.
   assign word_o = {byte_i, shift_q[31:8]};
   assign done_o = valid_i && (idx_q == LastIdx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else if (clear_i) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else if (valid_i) begin
         idx_q   <= idx_q + 2'd1;  // wraps 3 -> 0
         shift_q <= word_o;
      end
   end

endmodule

// File: rtl/boot_ctrl.sv
// Boot loader: receives a word-count header and program words over a byte stream, writes
// them into instruction memory, then releases the CPU core from reset.
//   clk, reset : clock and async active-low reset
//   bus        : boot_ctrl_if.slave (stream in, imem write port, status out)
module boot_ctrl
   import boot_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 64
) (
   input  logic  clk,
   input  logic  reset,
   boot_ctrl_if.slave bus
);

   localparam logic [16:0] MaxWords = 17'(IMEM_WORDS);

   boot_state_e state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [15:0] words_q;
   logic        imem_we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        rx_ready_q;
   logic        busy_q;
   logic        error_q;
   logic        core_reset_q;

   logic        byte_acc;
   logic        restart;
   logic        word_done;
   logic [31:0] word;
   logic [15:0] n_full;

   assign byte_acc = bus.rx_valid && rx_ready_q;
   assign restart  = bus.boot_req && ((state_q == StRun) || (state_q == StError));
   assign n_full   = {bus.rx_data, n_q[7:0]};

   byte_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .clear_i (restart),
      .valid_i (byte_acc && (state_q == StData)),
      .byte_i  (bus.rx_data),
      .word_o  (word),
      .done_o  (word_done)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      unique case (state_q)
         StHdr0: begin
            if (byte_acc) begin
               n_d     = {8'h00, bus.rx_data};
               state_d = StHdr1;
            end
         end
         StHdr1: begin
            if (byte_acc) begin
               n_d = n_full;
               if ((n_full == 16'd0) || ({1'b0, n_full} > MaxWords)) begin
                  state_d = StError;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            // words_q still holds the index of the word being completed here
            if (word_done && (words_q == n_q - 16'd1)) begin
               state_d = StFin;
            end
         end
         StFin: state_d = StRun;
         StRun, StError: begin
            if (bus.boot_req) begin
               state_d = StHdr0;
               n_d     = '0;
            end
         end
         default: state_d = StHdr0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StHdr0;
         n_q          <= '0;
         words_q      <= '0;
         imem_we_q    <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rx_ready_q   <= 1'b1;
         busy_q       <= 1'b1;
         error_q      <= 1'b0;
         core_reset_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         imem_we_q <= word_done;
         if (restart) begin
            words_q <= '0;
         end else if (word_done) begin
            // word count doubles as the write index; N <= IMEM_WORDS so it never wraps
            words_q <= words_q + 16'd1;
            addr_q  <= {14'b0, words_q, 2'b00};
            wdata_q <= word;
         end
         // Status flags are registered from the next state so they align with state_q.
         rx_ready_q   <= takes_bytes(state_d);
         busy_q       <= is_busy(state_d);
         error_q      <= (state_d == StError);
         core_reset_q <= (state_d != StRun);
      end
   end

   assign bus.rx_ready     = rx_ready_q;
   assign bus.imem_we      = imem_we_q;
   assign bus.imem_addr    = addr_q;
   assign bus.imem_wdata   = wdata_q;
   assign bus.core_reset   = core_reset_q;
   assign bus.busy         = busy_q;
   assign bus.error        = error_q;
   assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_boot_ctrl.sv
module tb_boot_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   boot_ctrl_if bif ();

   boot_ctrl #(.IMEM_WORDS(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   int checks = 0;
   int fails  = 0;

   // write monitor
   int          cyc         = 0;
   int          we_count    = 0;
   int          last_we_cyc = -1;
   int          fall_cyc    = -1;
   logic        prev_cr     = 1'b1;
   logic [31:0] wr_addr [0:255];
   logic [31:0] wr_data [0:255];

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (bif.imem_we === 1'b1) begin
         if (we_count < 256) begin
            wr_addr[we_count] = bif.imem_addr;
            wr_data[we_count] = bif.imem_wdata;
         end
         we_count    = we_count + 1;
         last_we_cyc = cyc;
      end
      if (prev_cr === 1'b1 && bif.core_reset === 1'b0) fall_cyc = cyc;
      prev_cr = bif.core_reset;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      bif.rx_valid = 1'b1;
      bif.rx_data  = b;
      @(posedge clk);
      #1;
      bif.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_boot();
      bif.boot_req = 1'b1;
      @(posedge clk);
      #1;
      bif.boot_req = 1'b0;
   endtask

   task automatic test_reset();
      bif.rx_valid = 1'b0;
      bif.rx_data  = 8'h00;
      bif.boot_req = 1'b0;
      reset = 1'b0;
      idle(3);
      checks++; if (bif.core_reset !== 1'b1) begin fails++; $display("FAIL reset_core_reset: got %b want 1", bif.core_reset); end
      checks++; if (bif.imem_we !== 1'b0) begin fails++; $display("FAIL reset_imem_we: got %b want 0", bif.imem_we); end
      checks++; if (bif.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", bif.imem_addr); end
      checks++; if (bif.imem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", bif.imem_wdata); end
      checks++; if (bif.words_loaded !== 16'd0) begin fails++; $display("FAIL reset_words: got %0d want 0", bif.words_loaded); end
      checks++; if (bif.error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", bif.error); end
      checks++; if (bif.busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", bif.busy); end
      checks++; if (bif.rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready: got %b want 1", bif.rx_ready); end
      reset = 1'b1;
   endtask

   task automatic test_two_words();
      int base;
      logic [7:0] s [0:9];
      base = we_count;
      s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
      for (int i = 0; i < 10; i++) send_byte(s[i]);
      idle(3);
      checks++; if (we_count - base !== 2) begin fails++; $display("FAIL two_we_count: got %0d want 2", we_count - base); end
      checks++; if (wr_addr[base] !== 32'h0) begin fails++; $display("FAIL two_addr0: got %h want 0", wr_addr[base]); end
      checks++; if (wr_data[base] !== 32'h00000513) begin fails++; $display("FAIL two_data0: got %h want 00000513", wr_data[base]); end
      checks++; if (wr_addr[base+1] !== 32'h4) begin fails++; $display("FAIL two_addr1: got %h want 4", wr_addr[base+1]); end
      checks++; if (wr_data[base+1] !== 32'h00B505B3) begin fails++; $display("FAIL two_data1: got %h want 00b505b3", wr_data[base+1]); end
      checks++; if (bif.words_loaded !== 16'd2) begin fails++; $display("FAIL two_words: got %0d want 2", bif.words_loaded); end
      checks++; if (bif.core_reset !== 1'b0) begin fails++; $display("FAIL two_core_reset: got %b want 0", bif.core_reset); end
      checks++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL two_busy: got %b want 0", bif.busy); end
      checks++; if (bif.rx_ready !== 1'b0) begin fails++; $display("FAIL two_rx_ready: got %b want 0", bif.rx_ready); end
      checks++; if (fall_cyc - last_we_cyc !== 1) begin fails++; $display("FAIL two_release_delay: got %0d want 1", fall_cyc - last_we_cyc); end
   endtask

   task automatic test_boot_req_run();
      pulse_boot();
      checks++; if (bif.core_reset !== 1'b1) begin fails++; $display("FAIL run_req_core_reset: got %b want 1", bif.core_reset); end
      checks++; if (bif.busy !== 1'b1) begin fails++; $display("FAIL run_req_busy: got %b want 1", bif.busy); end
      checks++; if (bif.words_loaded !== 16'd0) begin fails++; $display("FAIL run_req_words: got %0d want 0", bif.words_loaded); end
      checks++; if (bif.rx_ready !== 1'b1) begin fails++; $display("FAIL run_req_rx_ready: got %b want 1", bif.rx_ready); end
   endtask

   task automatic test_zero_header();
      int base;
      base = we_count;
      send_byte(8'h00);
      send_byte(8'h00);
      checks++; if (bif.error !== 1'b1) begin fails++; $display("FAIL zero_error: got %b want 1", bif.error); end
      checks++; if (bif.rx_ready !== 1'b0) begin fails++; $display("FAIL zero_rx_ready: got %b want 0", bif.rx_ready); end
      checks++; if (bif.core_reset !== 1'b1) begin fails++; $display("FAIL zero_core_reset: got %b want 1", bif.core_reset); end
      checks++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b want 0", bif.busy); end
      idle(2);
      checks++; if (we_count - base !== 0) begin fails++; $display("FAIL zero_no_write: got %0d want 0", we_count - base); end
      pulse_boot();
      checks++; if (bif.error !== 1'b0) begin fails++; $display("FAIL zero_recover_error: got %b want 0", bif.error); end
      checks++; if (bif.busy !== 1'b1) begin fails++; $display("FAIL zero_recover_busy: got %b want 1", bif.busy); end
   endtask

   task automatic test_too_big();
      send_byte(8'h41);
      send_byte(8'h00);
      checks++; if (bif.error !== 1'b1) begin fails++; $display("FAIL big_error: got %b want 1", bif.error); end
      pulse_boot();
      checks++; if (bif.error !== 1'b0) begin fails++; $display("FAIL big_recover: got %b want 0", bif.error); end
   endtask

   task automatic test_full();
      int base;
      int bad;
      logic [7:0] b;
      logic [31:0] exp;
      base = we_count;
      send_byte(8'h40);
      send_byte(8'h00);
      for (int i = 0; i < 64; i++) begin
         b = 8'(i);
         send_byte(b);
         send_byte(8'hA5);
         send_byte(8'h3C);
         send_byte(~b);
      end
      idle(3);
      checks++; if (we_count - base !== 64) begin fails++; $display("FAIL full_we_count: got %0d want 64", we_count - base); end
      checks++; if (wr_addr[base+63] !== 32'hFC) begin fails++; $display("FAIL full_last_addr: got %h want fc", wr_addr[base+63]); end
      checks++; if (wr_data[base+63] !== 32'hC03CA53F) begin fails++; $display("FAIL full_last_data: got %h want c03ca53f", wr_data[base+63]); end
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         b   = 8'(i);
         exp = {~b, 8'h3C, 8'hA5, b};
         if (wr_addr[base+i] !== 32'(i * 4) || wr_data[base+i] !== exp) bad++;
      end
      checks++; if (bad !== 0) begin fails++; $display("FAIL full_all_words: got %0d bad words want 0", bad); end
      checks++; if (bif.words_loaded !== 16'd64) begin fails++; $display("FAIL full_words: got %0d want 64", bif.words_loaded); end
      checks++; if (bif.core_reset !== 1'b0 || bif.busy !== 1'b0) begin fails++; $display("FAIL full_run: got core_reset=%b busy=%b want 0 0", bif.core_reset, bif.busy); end
   endtask

   task automatic test_gaps();
      int base;
      logic [7:0] s [0:3];
      pulse_boot();
      base = we_count;
      s = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_byte(8'h01);
      send_byte(8'h00);
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 3));
         send_byte(s[i]);
         idle($urandom_range(0, 3));
      end
      idle(3);
      checks++; if (we_count - base !== 1) begin fails++; $display("FAIL gaps_we_count: got %0d want 1", we_count - base); end
      checks++; if (wr_data[base] !== 32'hDEADBEEF) begin fails++; $display("FAIL gaps_data: got %h want deadbeef", wr_data[base]); end
      checks++; if (wr_addr[base] !== 32'h0) begin fails++; $display("FAIL gaps_addr: got %h want 0", wr_addr[base]); end
      checks++; if (bif.core_reset !== 1'b0) begin fails++; $display("FAIL gaps_core_reset: got %b want 0", bif.core_reset); end
   endtask

   task automatic test_reset_mid();
      int base;
      pulse_boot();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      reset = 1'b0;
      #2;
      checks++; if (bif.imem_wdata !== 32'h0) begin fails++; $display("FAIL mid_rst_wdata: got %h want 0", bif.imem_wdata); end
      checks++; if (bif.rx_ready !== 1'b1 || bif.busy !== 1'b1 || bif.core_reset !== 1'b1) begin fails++; $display("FAIL mid_rst_flags: got rx_ready=%b busy=%b core_reset=%b want 1 1 1", bif.rx_ready, bif.busy, bif.core_reset); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      base = we_count;
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
      idle(3);
      checks++; if (we_count - base !== 1) begin fails++; $display("FAIL mid_we_count: got %0d want 1", we_count - base); end
      checks++; if (wr_data[base] !== 32'h12345678) begin fails++; $display("FAIL mid_data: got %h want 12345678", wr_data[base]); end
      checks++; if (wr_addr[base] !== 32'h0) begin fails++; $display("FAIL mid_addr: got %h want 0", wr_addr[base]); end
   endtask

   task automatic test_boot_req_in_data();
      int base;
      pulse_boot();
      base = we_count;
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      pulse_boot();
      checks++; if (bif.busy !== 1'b1 || bif.rx_ready !== 1'b1) begin fails++; $display("FAIL data_req_ignored: got busy=%b rx_ready=%b want 1 1", bif.busy, bif.rx_ready); end
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      idle(3);
      checks++; if (we_count - base !== 1) begin fails++; $display("FAIL data_req_we_count: got %0d want 1", we_count - base); end
      checks++; if (wr_data[base] !== 32'hDDCCBBAA) begin fails++; $display("FAIL data_req_data: got %h want ddccbbaa", wr_data[base]); end
      checks++; if (bif.core_reset !== 1'b0) begin fails++; $display("FAIL data_req_core_reset: got %b want 0", bif.core_reset); end
      checks++; if (fall_cyc - last_we_cyc !== 1) begin fails++; $display("FAIL data_req_release_delay: got %0d want 1", fall_cyc - last_we_cyc); end
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_boot_req_run();
      test_zero_header();
      test_too_big();
      test_full();
      test_gaps();
      test_reset_mid();
      test_boot_req_in_data();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
